// File: rtl/bldc_commute_ctrl.sv
// Six-step hall-commutated BLDC gate sequencer: hall synchronizer, high-side PWM,
// dead-time insertion on every sector/direction change and a latched fault shutdown.
module bldc_commute_ctrl #(
  parameter int PWM_BITS    = 10,
  parameter int DEAD_CYCLES = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                dir,
  input  logic [PWM_BITS-1:0] duty,
  input  logic                SA_in,
  input  logic                SB_in,
  input  logic                SC_in,
  input  logic                hall_fault,
  input  logic                clear_fault,
  output logic                AH,
  output logic                AL,
  output logic                BH,
  output logic                BL,
  output logic                CH,
  output logic                CL,
  output logic [1:0]          state,
  output logic                fault_latched
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DEAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;
  localparam logic [PWM_BITS-1:0] PCNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEAD_CYCLES - 1);

  logic [2:0]          sync1_q, hs_q;
  logic [PWM_BITS-1:0] pcnt_q, duty_q;
  logic [1:0]          state_q, state_d;
  logic [DW-1:0]       dcnt_q, dcnt_d;
  logic [3:0]          applied_q, applied_d, prev_q;
  logic [5:0]          gates_q, gates_d;
  logic [2:0]          tbl_hi, tbl_lo, hi_oh, lo_oh;
  logic [3:0]          cur_dh;
  logic                hs_valid, pwm_on, run_d;

  assign cur_dh   = {dir, hs_q};
  assign hs_valid = (hs_q != 3'b000) && (hs_q != 3'b111);
  assign pwm_on   = (pcnt_q < duty_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      hs_q    <= '0;
      pcnt_q  <= '0;
      duty_q  <= '0;
    end else begin
      sync1_q <= {SA_in, SB_in, SC_in};
      hs_q    <= sync1_q;
      pcnt_q  <= (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
      if (pcnt_q == '0) duty_q <= duty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      dcnt_q    <= '0;
      applied_q <= '0;
      prev_q    <= '0;
      gates_q   <= '0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      applied_q <= applied_d;
      prev_q    <= cur_dh;
      gates_q   <= gates_d;
    end
  end

  // Priority: fault > disable > sector/direction change.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    applied_d = applied_q;
    if (state_q == S_FAULT) begin
      if (clear_fault && hall_fault && !enable) state_d = S_IDLE;
    end else if (!hall_fault || ((state_q != S_IDLE) && !hs_valid)) begin
      state_d = S_FAULT;
    end else if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (hs_valid) begin
          state_d = S_DEAD;
          dcnt_d  = '0;
        end
        S_DEAD: begin
          if (cur_dh != prev_q) begin
            dcnt_d = '0;
          end else if (dcnt_q == DCNT_LAST) begin
            state_d   = S_RUN;
            applied_d = cur_dh;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
        S_RUN: if (cur_dh != applied_q) begin
          state_d = S_DEAD;
          dcnt_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // Forward commutation table as one-hot {A,B,C}; reverse swaps high and low.
  always_comb begin
    tbl_hi = 3'b000;
    tbl_lo = 3'b000;
    case (applied_d[2:0])
      3'b100: begin tbl_hi = 3'b100; tbl_lo = 3'b001; end
      3'b110: begin tbl_hi = 3'b010; tbl_lo = 3'b001; end
      3'b010: begin tbl_hi = 3'b010; tbl_lo = 3'b100; end
      3'b011: begin tbl_hi = 3'b001; tbl_lo = 3'b100; end
      3'b001: begin tbl_hi = 3'b001; tbl_lo = 3'b010; end
      3'b101: begin tbl_hi = 3'b100; tbl_lo = 3'b010; end
      default: ;
    endcase
    hi_oh = applied_d[3] ? tbl_hi : tbl_lo;
    lo_oh = applied_d[3] ? tbl_lo : tbl_hi;
  end

  assign run_d = (state_d == S_RUN);

  for (genvar gi = 0; gi < 3; gi++) begin : g_phase
    assign gates_d[5-2*gi] = run_d & hi_oh[2-gi] & pwm_on;
    assign gates_d[4-2*gi] = run_d & lo_oh[2-gi];
  end

  assign {AH, AL, BH, BL, CH, CL} = gates_q;
  assign state         = state_q;
  assign fault_latched = (state_q == S_FAULT);
endmodule

// File: tb/tb_bldc_commute_ctrl.sv
// Scoreboard bench for bldc_commute_ctrl: directed scenarios plus random halls/dir/duty/faults,
// every cycle compared against a behavioural reference model.
module tb_bldc_commute_ctrl;
  localparam int PWM_BITS    = 10;
  localparam int DEAD_CYCLES = 25;
  localparam int PERIOD      = (1 << PWM_BITS) - 1;
  localparam int IDLE = 0, DEAD = 1, RUN = 2, FLT = 3;

  logic clk = 1'b0;
  logic reset, enable, dir, SA_in, SB_in, SC_in, hall_fault, clear_fault;
  logic [PWM_BITS-1:0] duty;
  logic AH, AL, BH, BL, CH, CL, fault_latched;
  logic [1:0] state;

  always #5 clk = ~clk;

  bldc_commute_ctrl #(.PWM_BITS(PWM_BITS), .DEAD_CYCLES(DEAD_CYCLES)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .duty(duty),
    .SA_in(SA_in), .SB_in(SB_in), .SC_in(SC_in), .hall_fault(hall_fault),
    .clear_fault(clear_fault), .AH(AH), .AL(AL), .BH(BH), .BL(BL), .CH(CH), .CL(CL),
    .state(state), .fault_latched(fault_latched)
  );

  typedef struct packed { logic [5:0] gates; logic [1:0] st; } exp_t;
  typedef struct packed { int got; int want; } meas_t;
  exp_t  exp_q[$];
  meas_t meas_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    done = 1'b0;

  // Phase index (0=A,1=B,2=C) of the forward high and low switch per hall code.
  int HI[8]  = '{0, 2, 1, 2, 0, 0, 1, 0};
  int LO[8]  = '{0, 1, 0, 0, 2, 1, 2, 0};
  int FWD[6] = '{4, 6, 2, 3, 1, 5};

  // Reference model: cycles since reset, raw-hall history, and a stability streak in dead time.
  int m_k, m_duty, m_mode, m_streak, m_prev, m_applied;
  int m_hist[$];
  int ah_acc;
  int idx;

  function automatic logic [5:0] pattern(int dh, bit pwm);
    logic [5:0] g;
    int h, l, t;
    g = '0;
    h = HI[dh % 8];
    l = LO[dh % 8];
    if (dh < 8) begin t = h; h = l; l = t; end
    if (pwm) g[5-2*h] = 1'b1;
    g[4-2*l] = 1'b1;
    return g;
  endfunction

  task automatic model_step();
    int raw, hs, cur, nm;
    bit valid, pwm;
    exp_t e;
    raw = int'({SA_in, SB_in, SC_in});
    if (reset) begin
      m_k = 0; m_duty = 0; m_mode = IDLE; m_streak = 0; m_prev = 0; m_applied = 0;
      m_hist = '{0, 0};
      e.gates = '0;
      e.st = 2'd0;
    end else begin
      hs    = m_hist[0];
      cur   = (int'(dir) << 3) | hs;
      valid = (hs != 0) && (hs != 7);
      pwm   = ((m_k % PERIOD) < m_duty);
      nm    = m_mode;
      if (m_mode == FLT) begin
        if (clear_fault && hall_fault && !enable) nm = IDLE;
      end else if (!hall_fault || (m_mode != IDLE && !valid)) begin
        nm = FLT;
      end else if (!enable) begin
        nm = IDLE;
      end else if (m_mode == IDLE) begin
        if (valid) begin nm = DEAD; m_streak = 1; end
      end else if (m_mode == DEAD) begin
        m_streak = (cur == m_prev) ? m_streak + 1 : 1;
        if (m_streak == DEAD_CYCLES + 1) begin nm = RUN; m_applied = cur; end
      end else if (cur != m_applied) begin
        nm = DEAD; m_streak = 1;
      end
      if (m_k % PERIOD == 0) m_duty = int'(duty);
      m_k++;
      m_prev = cur;
      void'(m_hist.pop_front());
      m_hist.push_back(raw);
      m_mode  = nm;
      e.gates = (nm == RUN) ? pattern(m_applied, pwm) : 6'b0;
      e.st    = 2'(nm);
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    ah_acc += int'(AH);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hall(int v);
    {SA_in, SB_in, SC_in} = 3'(v);
  endtask

  task automatic measure_ah(int want);
    ah_acc = 0;
    run(PERIOD);
    meas_q.push_back('{got: ah_acc, want: want});
  endtask

  // Monitor: sole consumer of the scoreboard queues and sole writer of the counters.
  exp_t  mon_e;
  meas_t mon_m;
  int    nh, nl;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({AH, AL, BH, BL, CH, CL} !== mon_e.gates) begin
        errors++;
        $display("FAIL gates t=%0t got %b want %b", $time, {AH, AL, BH, BL, CH, CL}, mon_e.gates);
      end
      checks++;
      if ({state, fault_latched} !== {mon_e.st, mon_e.st == 2'd3}) begin
        errors++;
        $display("FAIL state t=%0t got %0d/%b want %0d/%b", $time, state, fault_latched,
                 mon_e.st, mon_e.st == 2'd3);
      end
      nh = int'(AH) + int'(BH) + int'(CH);
      nl = int'(AL) + int'(BL) + int'(CL);
      checks++;
      if (nh > 1 || nl > 1 || (AH && AL) || (BH && BL) || (CH && CL)) begin
        errors++;
        $display("FAIL interlock t=%0t got %b want at most one H, one L, no xH&xL",
                 $time, {AH, AL, BH, BL, CH, CL});
      end
    end
    if (meas_q.size() > 0) begin
      mon_m = meas_q.pop_front();
      checks++;
      if (mon_m.got != mon_m.want) begin
        errors++;
        $display("FAIL ah_on_count t=%0t got %0d want %0d", $time, mon_m.got, mon_m.want);
      end
    end
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || meas_q.size() != 0) begin
        errors++;
        $display("FAIL drain got %0d/%0d pending want 0/0", exp_q.size(), meas_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b1; dir = 1'b1; duty = 10'd512;
    hall_fault = 1'b1; clear_fault = 1'b0; idx = 0; ah_acc = 0;
    hall(FWD[0]);
    run(3);
    reset = 1'b0;
    run(40);

    // Forward rotation through all six sectors.
    for (int i = 0; i < 6; i++) begin
      idx = (idx + 1) % 6;
      hall(FWD[idx]);
      run(60);
    end
    run(2 * PERIOD);
    measure_ah(512);

    // Direction reversal at hs=010, then duty extremes.
    idx = 2; hall(FWD[idx]); run(40);
    dir = 1'b0; run(40);
    duty = '0; run(2 * PERIOD); measure_ah(0);
    duty = 10'd1023; run(2 * PERIOD); measure_ah(PERIOD);
    duty = 10'd300;

    // Fault pulse, refused clear while enabled, simultaneous fault+clear, proper clear.
    hall_fault = 1'b0; tick(); hall_fault = 1'b1; run(4);
    clear_fault = 1'b1; tick(); clear_fault = 1'b0; run(3);
    enable = 1'b0; hall_fault = 1'b0; clear_fault = 1'b1; tick();
    hall_fault = 1'b1; clear_fault = 1'b0; run(2);
    clear_fault = 1'b1; tick(); clear_fault = 1'b0; run(3);
    enable = 1'b1; dir = 1'b1; run(40);

    // Invalid hall during dead time, recovery, then hall toggling inside the dead window.
    idx = (idx + 1) % 6; hall(FWD[idx]); run(5);
    hall(7); run(5);
    hall(FWD[idx]); enable = 1'b0; clear_fault = 1'b1; tick();
    clear_fault = 1'b0; enable = 1'b1; run(40);
    for (int t = 0; t < 4; t++) begin
      idx = (idx + 1) % 6; hall(FWD[idx]); run(8);
    end
    run(40);

    // Reset in mid-run.
    reset = 1'b1; tick(); reset = 1'b0; run(40);

    // Random operation.
    for (int c = 0; c < 20000; c++) begin
      reset = ($urandom_range(0, 4999) == 0);
      if ($urandom_range(0, 49) == 0) begin
        idx = (idx + (($urandom_range(0, 1) == 1) ? 1 : 5)) % 6;
        hall(FWD[idx]);
      end else if ($urandom_range(0, 2999) == 0) begin
        hall(($urandom_range(0, 1) == 1) ? 7 : 0);
      end
      if ($urandom_range(0, 499) == 0) dir = ~dir;
      if ($urandom_range(0, 299) == 0) duty = PWM_BITS'($urandom_range(0, PERIOD));
      if (enable) enable = ($urandom_range(0, 1499) != 0);
      else enable = ($urandom_range(0, 19) == 0);
      hall_fault  = ($urandom_range(0, 1999) != 0);
      clear_fault = ($urandom_range(0, 9) == 0);
      tick();
    end
    reset = 1'b0; clear_fault = 1'b0;
    run(3);
    done = 1'b1;
    repeat (10) @(negedge clk);
    $display("FAIL watchdog got no summary want summary");
    $fatal(1);
  end
endmodule
